// File: rtl/dcsk_tx_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// dcsk_tx_sequencer_pkg
//   Shared types for the DCSK transmit sequencer:
//   - sf_code_t        : 2-bit spreading-factor code (SF2/SF4/SF8/SF16)
//   - dcsk_seq_state_t : sequencer FSM states
//   - sf_chips()       : maps a spreading-factor code to its chip count per half-bit
// ----------------------------------------------------------------------------
package dcsk_tx_sequencer_pkg;

   typedef enum logic [1:0] {
      SF2  = 2'd0,
      SF4  = 2'd1,
      SF8  = 2'd2,
      SF16 = 2'd3
   } sf_code_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REF   = 2'd1,
      DATA  = 2'd2,
      DRAIN = 2'd3
   } dcsk_seq_state_t;

   // Reference chips per bit: 2, 4, 8 or 16.
   function automatic int unsigned sf_chips(input logic [1:0] sf);
      return 32'd2 << sf;
   endfunction

endpackage

// File: rtl/dcsk_tx_sequencer_if.sv
// ----------------------------------------------------------------------------
// dcsk_tx_sequencer_if
//   Handshake bundle around the DCSK transmit sequencer. Signal names carry the
//   direction as seen from the sequencer.
//   Word channel : i_data, i_data_valid, o_data_ready
//   Chaos channel: o_chaos_req, i_chaos_sample, i_chaos_valid
//   Chip channel : o_chip, o_chip_valid, i_chip_ready
//   Modports: slave (the sequencer), master (word source / generator / sink).
// ----------------------------------------------------------------------------
interface dcsk_tx_sequencer_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CHIP_W = 8
);

   logic [DATA_W-1:0] i_data;
   logic              i_data_valid;
   logic              o_data_ready;
   logic              o_chaos_req;
   logic [CHIP_W-1:0] i_chaos_sample;
   logic              i_chaos_valid;
   logic [CHIP_W-1:0] o_chip;
   logic              o_chip_valid;
   logic              i_chip_ready;

   modport slave (
      input  i_data, i_data_valid, i_chaos_sample, i_chaos_valid, i_chip_ready,
      output o_data_ready, o_chaos_req, o_chip, o_chip_valid
   );

   modport master (
      output i_data, i_data_valid, i_chaos_sample, i_chaos_valid, i_chip_ready,
      input  o_data_ready, o_chaos_req, o_chip, o_chip_valid
   );

endinterface

// File: rtl/dcsk_ref_buffer.sv
// ----------------------------------------------------------------------------
// dcsk_ref_buffer
//   Reference-chip store: DEPTH x WIDTH register file, one synchronous write
//   port and one asynchronous read port. Storage is not reset.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
// ----------------------------------------------------------------------------
module dcsk_ref_buffer #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dcsk_tx_sequencer.sv
// ----------------------------------------------------------------------------
// dcsk_tx_sequencer
//   DCSK transmit sequencer. Accepts a data word, then for every bit (MSB
//   first) emits SF reference chips taken straight from the chaos generator,
//   followed by SF data chips that replay the buffered reference, negated
//   (saturating) when the bit is 0.
//   i_clk, i_arst_n    : clock, asynchronous active-low reset
//   i_spreading_factor : SF code, latched when a word is accepted
//   io_bus             : word / chaos / chip handshakes (slave side)
//   o_busy             : high from word accept until its last chip is taken
//   o_bit_index        : bit of the chip in the output register (0 = MSB)
//   o_chip_index       : chip of that bit, 0..2*SF-1
// ----------------------------------------------------------------------------
module dcsk_tx_sequencer
   import dcsk_tx_sequencer_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CHIP_W = 8,
   parameter int unsigned MAX_SF = 16
) (
   input  logic                          i_clk,
   input  logic                          i_arst_n,
   input  logic [1:0]                    i_spreading_factor,
   dcsk_tx_sequencer_if.slave            io_bus,
   output logic                          o_busy,
   output logic [$clog2(DATA_W)-1:0]     o_bit_index,
   output logic [$clog2(2*MAX_SF)-1:0]   o_chip_index
);

   localparam int unsigned BIW = $clog2(DATA_W);
   localparam int unsigned CIW = $clog2(2 * MAX_SF);
   localparam int unsigned AW  = $clog2(MAX_SF);

   // Saturating two's-complement negate: the most negative code maps to max positive.
   function automatic logic [CHIP_W-1:0] sat_neg(input logic [CHIP_W-1:0] x);
      if (x == {1'b1, {(CHIP_W-1){1'b0}}}) begin
         return {1'b0, {(CHIP_W-1){1'b1}}};
      end
      return ~x + 1'b1;
   endfunction

   dcsk_seq_state_t   r_state,      w_state_nxt;
   logic [DATA_W-1:0] r_shift,      w_shift_nxt;   // MSB is the bit being sent
   logic [CIW-1:0]    r_sf_chips,   w_sf_chips_nxt;
   logic [BIW-1:0]    r_bit_idx,    w_bit_idx_nxt;
   logic [CIW-1:0]    r_chip_idx,   w_chip_idx_nxt; // next chip to load
   logic [CHIP_W-1:0] r_chip,       w_chip_nxt;
   logic              r_chip_valid, w_chip_valid_nxt;
   logic              r_busy,       w_busy_nxt;
   logic [BIW-1:0]    r_out_bit,    w_out_bit_nxt;  // indices of the chip on o_chip
   logic [CIW-1:0]    r_out_chip,   w_out_chip_nxt;

   logic              w_slot_free;
   logic              w_ref_last;
   logic              w_data_last;
   logic [CIW-1:0]    w_two_sf_m1;
   logic              w_buf_we;
   logic [AW-1:0]     w_buf_waddr;
   logic [AW-1:0]     w_buf_raddr;
   logic [CHIP_W-1:0] w_buf_rdata;
   logic              w_chaos_req;
   logic              w_data_ready;

   assign w_slot_free = !r_chip_valid || io_bus.i_chip_ready;
   assign w_two_sf_m1 = {r_sf_chips[CIW-2:0], 1'b0} - 1'b1;
   assign w_ref_last  = (r_chip_idx == r_sf_chips - 1'b1);
   assign w_data_last = (r_chip_idx == w_two_sf_m1);
   assign w_buf_waddr = AW'(r_chip_idx);
   // Data chip k replays reference chip k = chip_index - SF.
   assign w_buf_raddr = AW'(r_chip_idx - r_sf_chips);

   dcsk_ref_buffer #(
      .DEPTH (MAX_SF),
      .WIDTH (CHIP_W)
   ) u_ref_buffer (
      .i_clk   (i_clk),
      .i_we    (w_buf_we),
      .i_waddr (w_buf_waddr),
      .i_wdata (io_bus.i_chaos_sample),
      .i_raddr (w_buf_raddr),
      .o_rdata (w_buf_rdata)
   );

   always_comb begin
      w_state_nxt      = r_state;
      w_shift_nxt      = r_shift;
      w_sf_chips_nxt   = r_sf_chips;
      w_bit_idx_nxt    = r_bit_idx;
      w_chip_idx_nxt   = r_chip_idx;
      w_chip_nxt       = r_chip;
      // A free slot with nothing loaded empties the output register.
      w_chip_valid_nxt = w_slot_free ? 1'b0 : r_chip_valid;
      w_busy_nxt       = r_busy;
      w_out_bit_nxt    = r_out_bit;
      w_out_chip_nxt   = r_out_chip;
      w_buf_we         = 1'b0;
      w_chaos_req      = 1'b0;
      w_data_ready     = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_data_ready = 1'b1;
            if (io_bus.i_data_valid) begin
               w_shift_nxt    = io_bus.i_data;
               w_sf_chips_nxt = CIW'(sf_chips(i_spreading_factor));
               w_bit_idx_nxt  = '0;
               w_chip_idx_nxt = '0;
               w_busy_nxt     = 1'b1;
               w_state_nxt    = REF;
            end
         end
         REF: begin
            w_chaos_req = w_slot_free;
            if (w_slot_free && io_bus.i_chaos_valid) begin
               w_chip_nxt       = io_bus.i_chaos_sample;
               w_chip_valid_nxt = 1'b1;
               w_buf_we         = 1'b1;
               w_out_bit_nxt    = r_bit_idx;
               w_out_chip_nxt   = r_chip_idx;
               w_chip_idx_nxt   = r_chip_idx + 1'b1;
               if (w_ref_last) begin
                  w_state_nxt = DATA;
               end
            end
         end
         DATA: begin
            if (w_slot_free) begin
               w_chip_nxt       = r_shift[DATA_W-1] ? w_buf_rdata : sat_neg(w_buf_rdata);
               w_chip_valid_nxt = 1'b1;
               w_out_bit_nxt    = r_bit_idx;
               w_out_chip_nxt   = r_chip_idx;
               if (w_data_last) begin
                  w_chip_idx_nxt = '0;
                  if (r_bit_idx != BIW'(DATA_W - 1)) begin
                     w_bit_idx_nxt = r_bit_idx + 1'b1;
                     w_shift_nxt   = r_shift << 1;
                     w_state_nxt   = REF;
                  end else begin
                     w_state_nxt = DRAIN;
                  end
               end else begin
                  w_chip_idx_nxt = r_chip_idx + 1'b1;
               end
            end
         end
         DRAIN: begin
            // Slot free here means the final chip has been taken.
            if (w_slot_free) begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_state      <= IDLE;
         r_shift      <= '0;
         r_sf_chips   <= '0;
         r_bit_idx    <= '0;
         r_chip_idx   <= '0;
         r_chip       <= '0;
         r_chip_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_out_bit    <= '0;
         r_out_chip   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_shift      <= w_shift_nxt;
         r_sf_chips   <= w_sf_chips_nxt;
         r_bit_idx    <= w_bit_idx_nxt;
         r_chip_idx   <= w_chip_idx_nxt;
         r_chip       <= w_chip_nxt;
         r_chip_valid <= w_chip_valid_nxt;
         r_busy       <= w_busy_nxt;
         r_out_bit    <= w_out_bit_nxt;
         r_out_chip   <= w_out_chip_nxt;
      end
   end

   assign io_bus.o_data_ready = w_data_ready;
   assign io_bus.o_chaos_req  = w_chaos_req;
   assign io_bus.o_chip       = r_chip;
   assign io_bus.o_chip_valid = r_chip_valid;
   assign o_busy              = r_busy;
   assign o_bit_index         = r_out_bit;
   assign o_chip_index        = r_out_chip;

endmodule

// File: tb/tb_dcsk_tx_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dcsk_tx_sequencer
//   Scoreboard bench for dcsk_tx_sequencer. Each issued word pushes its full
//   expected chip stream; a monitor pops one entry per accepted chip.
// ----------------------------------------------------------------------------
module tb_dcsk_tx_sequencer;
   import dcsk_tx_sequencer_pkg::*;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CHIP_W = 8;
   localparam int unsigned MAX_SF = 16;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] sf_code;
   logic       busy;
   logic [2:0] bit_idx;
   logic [4:0] chip_idx;

   dcsk_tx_sequencer_if #(.DATA_W(DATA_W), .CHIP_W(CHIP_W)) u_if ();

   dcsk_tx_sequencer #(
      .DATA_W (DATA_W),
      .CHIP_W (CHIP_W),
      .MAX_SF (MAX_SF)
   ) u_dut (
      .i_clk              (clk),
      .i_arst_n           (rst_n),
      .i_spreading_factor (sf_code),
      .io_bus             (u_if),
      .o_busy             (busy),
      .o_bit_index        (bit_idx),
      .o_chip_index       (chip_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] chip;
      logic [2:0] bit_i;
      logic [4:0] chip_i;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned n_taken = 0;     // chaos samples consumed so far
   int          chaos_mode = 0;
   logic        take_flag = 1'b0;
   bit          rand_ready = 1'b0;
   bit          gap_en = 1'b0;
   int unsigned gap_sf = 8;

   function automatic logic [7:0] exp_sample(input int unsigned n, input int mode);
      if (mode == 1) return n[0] ? 8'h7F : 8'h80;
      return 8'(n * 29 + 3);
   endfunction

   function automatic logic [7:0] neg_sat(input logic [7:0] x);
      if (x == 8'h80) return 8'h7F;
      return 8'(9'h100 - {1'b0, x});
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Chaos generator: holds a sample until the DUT takes it.
   always @(negedge clk) take_flag <= u_if.o_chaos_req && u_if.i_chaos_valid && rst_n;

   initial begin
      u_if.i_chaos_sample = exp_sample(0, 0);
      forever begin
         @(posedge clk);
         if (take_flag) n_taken++;
         #2;
         u_if.i_chaos_sample = exp_sample(n_taken, chaos_mode);
      end
   end

   // Downstream sink.
   initial begin
      u_if.i_chip_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         u_if.i_chip_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: scoreboard pop, stall hold, data-half gap checks.
   initial begin
      logic       prev_stall;
      logic [7:0] prev_chip;
      logic       prev_hs;
      logic [4:0] prev_idx;
      logic       hs;
      exp_t       e;
      prev_stall = 1'b0;
      prev_hs    = 1'b0;
      prev_chip  = '0;
      prev_idx   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
            prev_hs    = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid_held", u_if.o_chip_valid, 1);
               check("stall_chip_held", u_if.o_chip, prev_chip);
            end
            hs = u_if.o_chip_valid && u_if.i_chip_ready;
            if (hs) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_chip: got %0h, expected no chip", u_if.o_chip);
               end else begin
                  e = exp_q.pop_front();
                  check("chip", u_if.o_chip, e.chip);
                  check("bit_index", bit_idx, e.bit_i);
                  check("chip_index", chip_idx, e.chip_i);
               end
               if (gap_en && chip_idx >= gap_sf) begin
                  check("data_no_gap", {prev_hs, prev_idx}, {1'b1, 5'(chip_idx - 5'd1)});
               end
            end
            prev_stall = u_if.o_chip_valid && !u_if.i_chip_ready;
            prev_chip  = u_if.o_chip;
            prev_hs    = hs;
            prev_idx   = chip_idx;
         end
      end
   end

   task automatic send_word(input logic [1:0] sf, input logic [7:0] data);
      int unsigned spc;
      int unsigned n0;
      exp_t        e;
      logic [7:0]  r;
      spc = (sf == SF2) ? 2 : (sf == SF4) ? 4 : (sf == SF8) ? 8 : 16;
      @(posedge clk);
      #1;
      n0 = n_taken;
      for (int b = 0; b < 8; b++) begin
         for (int j = 0; j < int'(spc); j++) begin
            e.chip   = exp_sample(n0 + b * spc + j, chaos_mode);
            e.bit_i  = 3'(b);
            e.chip_i = 5'(j);
            exp_q.push_back(e);
         end
         for (int j = 0; j < int'(spc); j++) begin
            r        = exp_sample(n0 + b * spc + j, chaos_mode);
            e.chip   = data[7-b] ? r : neg_sat(r);
            e.bit_i  = 3'(b);
            e.chip_i = 5'(spc + j);
            exp_q.push_back(e);
         end
      end
      sf_code           = sf;
      u_if.i_data       = data;
      u_if.i_data_valid = 1'b1;
      @(negedge clk);
      check("data_ready_at_accept", u_if.o_data_ready, 1);
      @(posedge clk);
      #1;
      u_if.i_data_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      while (exp_q.size() != 0 && cyc < 5000) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d chips outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end else begin
         check({name, "_busy_last"}, busy, 1);
         @(negedge clk);
         check({name, "_busy_done"}, busy, 0);
         check({name, "_valid_done"}, u_if.o_chip_valid, 0);
         check({name, "_ready_done"}, u_if.o_data_ready, 1);
      end
   endtask

   task automatic wait_chip(input string name, input logic [2:0] b, input logic [4:0] c);
      int cyc = 0;
      while (!(u_if.o_chip_valid && bit_idx == b && chip_idx == c) && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 5000) begin
         checks++;
         errors++;
         $display("FAIL %s_wait: got no chip at bit %0d chip %0d, expected one", name, b, c);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      sf_code             = SF2;
      u_if.i_data         = '0;
      u_if.i_data_valid   = 1'b0;
      u_if.i_chaos_valid  = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_chip_valid", u_if.o_chip_valid, 0);
      check("rst_chip", u_if.o_chip, 0);
      check("rst_chaos_req", u_if.o_chaos_req, 0);
      check("rst_busy", busy, 0);
      check("rst_bit_index", bit_idx, 0);
      check("rst_chip_index", chip_idx, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("idle_data_ready", u_if.o_data_ready, 1);

      // 1) SF2 baseline
      send_word(SF2, 8'hA5);
      wait_done("sf2");

      // 2) SF16, saturating negate on 0x80/0x7F samples
      chaos_mode = 1;
      send_word(SF16, 8'h00);
      wait_done("sf16_sat");
      chaos_mode = 0;

      // 3) SF4 with random backpressure
      rand_ready = 1'b1;
      send_word(SF4, 8'h4B);
      wait_done("sf4_stall");
      rand_ready = 1'b0;

      // 4) SF8, chaos stalls for 5 cycles mid-REF
      gap_en = 1'b1;
      gap_sf = 8;
      send_word(SF8, 8'h3C);
      wait_chip("chaos_stall", 3'd2, 5'd2);
      @(posedge clk);
      #1 u_if.i_chaos_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("chaos_req_held", u_if.o_chaos_req, 1);
         if (k > 0) check("ref_gap", u_if.o_chip_valid, 0);
      end
      @(posedge clk);
      #1 u_if.i_chaos_valid = 1'b1;
      wait_done("sf8_chaos");
      gap_en = 1'b0;

      // 5) SF change mid-word is ignored until the next word
      send_word(SF2, 8'h96);
      sf_code = SF16;
      wait_done("sf_change_a");
      send_word(SF16, 8'h69);
      wait_done("sf_change_b");

      // 6) Reset during DATA half of bit 3
      send_word(SF4, 8'hC3);
      wait_chip("mid_reset", 3'd3, 5'd5);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("abort_chip_valid", u_if.o_chip_valid, 0);
      check("abort_chip", u_if.o_chip, 0);
      check("abort_chaos_req", u_if.o_chaos_req, 0);
      check("abort_busy", busy, 0);
      check("abort_bit_index", bit_idx, 0);
      check("abort_chip_index", chip_idx, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_ready", u_if.o_data_ready, 1);
      check("post_reset_valid", u_if.o_chip_valid, 0);
      send_word(SF4, 8'h5A);
      wait_done("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
